// File: rtl/seven_bit_sub_pipe.sv
// Two-stage 7-bit subtractor (A - B - Bin) with valid/ready flow control.
// Define SUB_OVF_EN to add the signed-overflow output Ovf and its pipeline register.
module seven_bit_sub_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] A,
    input  logic [6:0] B,
    input  logic       Bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] Diff,
    output logic       Bout,
    output logic [7:0] txn_cnt
`ifdef SUB_OVF_EN
    ,
    output logic       Ovf
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holds its data until then and ready never waits on valid.

    logic       s1_valid_q, s1_valid_d;
    logic [4:0] s1_diff_lo_q, s1_diff_lo_d;
    logic       s1_borrow_q, s1_borrow_d;
    logic [1:0] s1_a_hi_q, s1_a_hi_d;
    logic [1:0] s1_b_hi_q, s1_b_hi_d;

    logic       s2_valid_q, s2_valid_d;
    logic [6:0] s2_diff_q, s2_diff_d;
    logic       s2_bout_q, s2_bout_d;
    logic [7:0] txn_cnt_q, txn_cnt_d;
`ifdef SUB_OVF_EN
    logic       s2_ovf_q, s2_ovf_d;
`endif

    logic       s2_advance;
    logic       in_fire;
    logic       s1_fire;
    logic       out_fire;
    logic [5:0] lo_sub;
    logic [2:0] hi_sub;

    assign s2_advance = !s2_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_advance;
    assign in_fire    = in_valid && in_ready;
    assign s1_fire    = s1_valid_q && s2_advance;
    assign out_fire   = s2_valid_q && out_ready;

    // Bit 5 of lo_sub / bit 2 of hi_sub is the borrow out of that chunk.
    assign lo_sub = {1'b0, A[4:0]} - {1'b0, B[4:0]} - {5'b0, Bin};
    assign hi_sub = {1'b0, s1_a_hi_q} - {1'b0, s1_b_hi_q} - {2'b0, s1_borrow_q};

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_diff_lo_d = s1_diff_lo_q;
        s1_borrow_d  = s1_borrow_q;
        s1_a_hi_d    = s1_a_hi_q;
        s1_b_hi_d    = s1_b_hi_q;
        if (in_fire) begin
            s1_valid_d   = 1'b1;
            s1_diff_lo_d = lo_sub[4:0];
            s1_borrow_d  = lo_sub[5];
            s1_a_hi_d    = A[6:5];
            s1_b_hi_d    = B[6:5];
        end else if (s1_fire) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_diff_d  = s2_diff_q;
        s2_bout_d  = s2_bout_q;
`ifdef SUB_OVF_EN
        s2_ovf_d   = s2_ovf_q;
`endif
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_diff_d = {hi_sub[1:0], s1_diff_lo_q};
                s2_bout_d = hi_sub[2];
`ifdef SUB_OVF_EN
                s2_ovf_d  = (s1_a_hi_q[1] != s1_b_hi_q[1]) && (hi_sub[1] != s1_a_hi_q[1]);
`endif
            end
        end
    end

    assign txn_cnt_d = out_fire ? txn_cnt_q + 8'd1 : txn_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_diff_lo_q <= 5'd0;
            s1_borrow_q  <= 1'b0;
            s1_a_hi_q    <= 2'd0;
            s1_b_hi_q    <= 2'd0;
            s2_valid_q   <= 1'b0;
            s2_diff_q    <= 7'd0;
            s2_bout_q    <= 1'b0;
            txn_cnt_q    <= 8'd0;
`ifdef SUB_OVF_EN
            s2_ovf_q     <= 1'b0;
`endif
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_diff_lo_q <= s1_diff_lo_d;
            s1_borrow_q  <= s1_borrow_d;
            s1_a_hi_q    <= s1_a_hi_d;
            s1_b_hi_q    <= s1_b_hi_d;
            s2_valid_q   <= s2_valid_d;
            s2_diff_q    <= s2_diff_d;
            s2_bout_q    <= s2_bout_d;
            txn_cnt_q    <= txn_cnt_d;
`ifdef SUB_OVF_EN
            s2_ovf_q     <= s2_ovf_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign Diff      = s2_diff_q;
    assign Bout      = s2_bout_q;
    assign txn_cnt   = txn_cnt_q;
`ifdef SUB_OVF_EN
    assign Ovf       = s2_ovf_q;
`endif

endmodule

// File: doc/seven_bit_sub_pipe.md
SEVEN_BIT_SUB_PIPE -- requirements
Module: seven_bit_sub_pipe

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising edge of clk.
REQ-003 SHALL have port in_valid, input, 1, operands A/B/Bin valid this cycle.
REQ-004 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-005 SHALL have port A, input, 7, minuend.
REQ-006 SHALL have port B, input, 7, subtrahend.
REQ-007 SHALL have port Bin, input, 1, borrow-in.
REQ-008 SHALL have port out_valid, output, 1, Diff/Bout valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result this cycle.
REQ-010 SHALL have port Diff, output, 7, A - B - Bin modulo 128.
REQ-011 SHALL have port Bout, output, 1, borrow-out (1 when A < B + Bin, unsigned).
REQ-012 SHALL have port txn_cnt, output, 8, count of completed output handshakes.
REQ-013 SHALL have port Ovf, output, 1, two's-complement signed overflow, present only with SUB_OVF_EN.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 computes Diff[4:0] and the low borrow from A[4:0], B[4:0], Bin and registers A[6:5], B[6:5]; stage 2 computes Diff[6:5] and Bout from the registered high bits and the stage-1 borrow.
REQ-015 SHALL give latency of exactly 2 cycles from input handshake (in_valid & in_ready) to out_valid with no backpressure.
REQ-016 SHALL sustain throughput of 1 transaction per cycle while out_ready=1.
REQ-017 SHALL transfer into stage 1 when in_valid & in_ready, and advance stage 1 to stage 2 when stage 2 is empty or is being consumed the same cycle.
REQ-018 SHALL drive in_ready = !s1_valid | s2_advance, where s2_advance = !out_valid | out_ready (combinational from out_ready).
REQ-019 SHALL hold Diff, Bout, Ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL hold pipeline contents unchanged when both stages are full and out_ready=0; no transaction may be dropped or duplicated.
REQ-021 SHALL support simultaneous input accept, stage advance and output consume in one cycle.
REQ-022 SHALL increment txn_cnt on every cycle where out_valid & out_ready, wrapping 255 -> 0.
REQ-023 SHALL ignore A/B/Bin whenever in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, clear both stage valid flags, set out_valid=0, Diff=0, Bout=0, Ovf=0, txn_cnt=0.
REQ-025 SHALL drive in_ready=1 during and after reset while the pipeline is empty.
REQ-026 SHALL discard in-flight transactions on reset mid-operation; no out_valid in the cycle after reset deasserts.
REQ-027 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-028 SHALL, with macro SUB_OVF_EN defined, provide port Ovf = (A[6] != B[6]) & (Diff[6] != A[6]), pipelined alongside Diff.
REQ-029 SHALL, without SUB_OVF_EN, omit port Ovf and its pipeline register; all other behaviour is identical.

Verification
REQ-030 SHALL cover basic: A=7'd100, B=7'd37, Bin=0, out_ready=1 -> 2 cycles later Diff=63, Bout=0, txn_cnt=1.
REQ-031 SHALL cover borrow wrap: A=0, B=1, Bin=1 -> Diff=7'd126, Bout=1; A=7'd31, B=7'd31, Bin=1 -> Diff=127, Bout=1 (low-chunk borrow crosses into stage 2).
REQ-032 SHALL cover backpressure: 4 back-to-back inputs (10-1, 20-2, 30-3, 40-4) with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted, Diff held at 9; on release outputs 9, 18, 27, 36 in order with no loss.
REQ-033 SHALL cover overflow with SUB_OVF_EN: A=7'h40 (-64), B=7'h01 -> Diff=7'h3F, Ovf=1; A=7'h10, B=7'h20 -> Ovf=0.
REQ-034 SHALL cover reset mid-flight: accept 2 transactions, assert rst 1 cycle -> out_valid=0, txn_cnt=0, in_ready=1 the next cycle.
REQ-035 SHALL cover counter wrap: 256 consumed transactions -> txn_cnt returns to 0.
